multi_pb_debouncer: RTL and testbench

MULTI_PB_DEBOUNCER -- requirements
Module: multi_pb_debouncer

---
 rtl/multi_pb_debouncer.sv | 93 +++++++++
 tb/tb_multi_pb_debouncer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_pb_debouncer.sv
// Multi-channel push-button debouncer: per-channel two-flop synchroniser, counter-based
// debounce, press/release pulses and a tick-driven long-press detector.
module multi_pb_debouncer #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 16,
    parameter int HOLD_W     = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] pb,
    input  logic            hold_tick,
    output logic [N_CH-1:0] pb_state,
    output logic [N_CH-1:0] pb_down,
    output logic [N_CH-1:0] pb_up,
    output logic [N_CH-1:0] pb_long,
    output logic            any_event
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = '1;
    localparam logic [HOLD_W-1:0] HOLD_PEN = HOLD_MAX - 1'b1;

    logic [N_CH-1:0]   pb_norm;
    logic [N_CH-1:0]   s0;
    logic [N_CH-1:0]   s1;
    logic [CNT_W-1:0]  cnt      [N_CH];
    logic [HOLD_W-1:0] hold_cnt [N_CH];
    logic [CNT_W-1:0]  cnt_nxt  [N_CH];
    logic [HOLD_W-1:0] hold_nxt [N_CH];
    logic [N_CH-1:0]   state_nxt;
    logic [N_CH-1:0]   down_nxt;
    logic [N_CH-1:0]   up_nxt;
    logic [N_CH-1:0]   long_nxt;

    assign pb_norm = ACTIVE_LOW ? ~pb : pb;

    // A release edge clears the hold counter even if a tick lands on it, so no long pulse can accompany pb_up.
    always_comb begin
        state_nxt = pb_state;
        down_nxt  = '0;
        up_nxt    = '0;
        long_nxt  = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_nxt[i]  = '0;
            hold_nxt[i] = hold_cnt[i];
            if (pb_state[i] != s1[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    state_nxt[i] = ~pb_state[i];
                    down_nxt[i]  = ~pb_state[i];
                    up_nxt[i]    = pb_state[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
            if (!pb_state[i] || up_nxt[i]) begin
                hold_nxt[i] = '0;
            end else if (hold_tick && (hold_cnt[i] != HOLD_MAX)) begin
                hold_nxt[i] = hold_cnt[i] + 1'b1;
                long_nxt[i] = (hold_cnt[i] == HOLD_PEN);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0        <= '0;
            s1        <= '0;
            pb_state  <= '0;
            pb_down   <= '0;
            pb_up     <= '0;
            pb_long   <= '0;
            any_event <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i]      <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            s0        <= pb_norm;
            s1        <= s0;
            pb_state  <= state_nxt;
            pb_down   <= down_nxt;
            pb_up     <= up_nxt;
            pb_long   <= long_nxt;
            any_event <= |{down_nxt, up_nxt, long_nxt};
            for (int i = 0; i < N_CH; i++) begin
                cnt[i]      <= cnt_nxt[i];
                hold_cnt[i] <= hold_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_pb_debouncer.sv
// Bench for multi_pb_debouncer: an active-low and an active-high instance fed mirrored pins,
// directed edge-count scenarios followed by random bouncing checked against a run-length model.
module tb_multi_pb_debouncer;

    localparam int N_CH     = 4;
    localparam int CNT_W    = 2;
    localparam int HOLD_W   = 2;
    localparam int DEB      = 1 << CNT_W;
    localparam int HOLD_LIM = (1 << HOLD_W) - 1;

    logic            clk;
    logic            rst_n;
    logic [N_CH-1:0] pb_a;
    logic [N_CH-1:0] pb_b;
    logic            hold_tick;
    logic [N_CH-1:0] state_a, down_a, up_a, long_a;
    logic [N_CH-1:0] state_b, down_b, up_b, long_b;
    logic            any_a, any_b;

    int total = 0;
    int bad   = 0;

    assign pb_b = ~pb_a;

    multi_pb_debouncer #(.N_CH(N_CH), .CNT_W(CNT_W), .HOLD_W(HOLD_W), .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .pb(pb_a), .hold_tick(hold_tick),
        .pb_state(state_a), .pb_down(down_a), .pb_up(up_a), .pb_long(long_a), .any_event(any_a)
    );

    multi_pb_debouncer #(.N_CH(N_CH), .CNT_W(CNT_W), .HOLD_W(HOLD_W), .ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .pb(pb_b), .hold_tick(hold_tick),
        .pb_state(state_b), .pb_down(down_b), .pb_up(up_b), .pb_long(long_b), .any_event(any_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: a level must disagree with the debounced state for DEB consecutive synchronised
    // cycles to flip it; a press emits one long pulse when it has collected HOLD_LIM counted ticks.
    bit [N_CH-1:0] m_state = '0;
    bit [N_CH-1:0] m_down  = '0;
    bit [N_CH-1:0] m_up    = '0;
    bit [N_CH-1:0] m_long  = '0;
    bit            m_any   = 1'b0;
    bit [N_CH-1:0] seen1   = '0;
    bit [N_CH-1:0] seen2   = '0;
    int            run   [N_CH] = '{default: 0};
    int            ticks [N_CH] = '{default: 0};

    always @(posedge clk or negedge rst_n) begin : model_blk
        bit [N_CH-1:0] lvl;
        bit            was;
        if (!rst_n) begin
            m_state = '0; m_down = '0; m_up = '0; m_long = '0; m_any = 1'b0;
            seen1 = '0; seen2 = '0;
            for (int i = 0; i < N_CH; i++) begin
                run[i]   = 0;
                ticks[i] = 0;
            end
        end else begin
            lvl    = ~pb_a;
            m_down = '0; m_up = '0; m_long = '0;
            for (int i = 0; i < N_CH; i++) begin
                was = m_state[i];
                if (seen2[i] != was) begin
                    run[i] = run[i] + 1;
                    if (run[i] == DEB) begin
                        run[i]     = 0;
                        m_state[i] = ~was;
                        if (!was) m_down[i] = 1'b1;
                        else      m_up[i]   = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
                if (!was || m_up[i]) begin
                    ticks[i] = 0;
                end else if (hold_tick && ticks[i] < HOLD_LIM) begin
                    ticks[i] = ticks[i] + 1;
                    if (ticks[i] == HOLD_LIM) m_long[i] = 1'b1;
                end
            end
            m_any = |{m_down, m_up, m_long};
            seen2 = seen1;
            seen1 = lvl;
        end
    end

    always @(negedge clk) begin
        total++;
        if ({state_a, down_a, up_a, long_a, any_a} !== {m_state, m_down, m_up, m_long, m_any}) begin
            bad++;
            $display("[TB] FAIL model_a t=%0t got st=%b dn=%b up=%b lg=%b any=%b exp st=%b dn=%b up=%b lg=%b any=%b",
                     $time, state_a, down_a, up_a, long_a, any_a, m_state, m_down, m_up, m_long, m_any);
        end
        total++;
        if ({state_b, down_b, up_b, long_b, any_b} !== {m_state, m_down, m_up, m_long, m_any}) begin
            bad++;
            $display("[TB] FAIL model_b t=%0t got st=%b dn=%b up=%b lg=%b any=%b exp st=%b dn=%b up=%b lg=%b any=%b",
                     $time, state_b, down_b, up_b, long_b, any_b, m_state, m_down, m_up, m_long, m_any);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N_CH-1:0] pins, input logic tick);
        pb_a      = pins;
        hold_tick = tick;
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(4'hF, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state_a", {state_a, down_a, up_a, long_a, any_a}, 0);
        checkOutput("reset_state_b", {state_b, down_b, up_b, long_b, any_b}, 0);
        #2 rst_n = 1'b1;

        // Three-cycle glitch on ch1 must vanish
        @(negedge clk);
        applyStimulus(4'b1101, 1'b0);
        waitNeg(3);
        applyStimulus(4'b1111, 1'b0);
        for (int k = 0; k < 10; k++) begin
            waitNeg(1);
            checkOutput("glitch_quiet", {state_a, down_a, any_a, state_b, any_b}, 0);
        end

        // Ch0 press: state and pb_down on the 6th edge
        applyStimulus(4'b1110, 1'b0);
        waitNeg(5);
        checkOutput("press_edge5_state", state_a, 4'b0000);
        waitNeg(1);
        checkOutput("press_edge6_a", {state_a, down_a, any_a}, {4'b0001, 4'b0001, 1'b1});
        checkOutput("press_edge6_b", {state_b, down_b, any_b}, {4'b0001, 4'b0001, 1'b1});
        checkOutput("model_down_pin", m_down, 4'b0001);
        waitNeg(1);
        checkOutput("press_edge7", {state_a, down_a, any_a}, {4'b0001, 4'b0000, 1'b0});

        // Five hold ticks: long pulse only on the third
        for (int t = 1; t <= 5; t++) begin
            applyStimulus(4'b1110, 1'b1);
            waitNeg(1);
            checkOutput($sformatf("long_tick%0d_a", t), {long_a, any_a}, (t == 3) ? {4'b0001, 1'b1} : 5'b0);
            checkOutput($sformatf("long_tick%0d_b", t), long_b, (t == 3) ? 4'b0001 : 4'b0000);
            applyStimulus(4'b1110, 1'b0);
            waitNeg(2);
        end
        checkOutput("model_long_ticks", ticks[0], HOLD_LIM);

        // Simultaneous release of ch0 and ch3 with a tick on the falling edge
        applyStimulus(4'b0110, 1'b0);
        waitNeg(8);
        checkOutput("ch0_ch3_pressed", state_a, 4'b1001);
        applyStimulus(4'b1111, 1'b0);
        waitNeg(5);
        checkOutput("release_edge5", {state_a, up_a}, {4'b1001, 4'b0000});
        applyStimulus(4'b1111, 1'b1);
        waitNeg(1);
        checkOutput("release_edge6_a", {state_a, up_a, long_a, any_a}, {4'b0000, 4'b1001, 4'b0000, 1'b1});
        checkOutput("release_edge6_b", {state_b, up_b, long_b}, {4'b0000, 4'b1001, 4'b0000});
        checkOutput("hold_cnt0_clear", dut_a.hold_cnt[0], 0);
        checkOutput("hold_cnt3_clear", dut_a.hold_cnt[3], 0);
        applyStimulus(4'b1111, 1'b0);
        waitNeg(3);

        // Async reset mid-count on ch2 while ch1 is pressed
        applyStimulus(4'b1101, 1'b0);
        waitNeg(8);
        checkOutput("ch1_pressed", state_a, 4'b0010);
        applyStimulus(4'b1001, 1'b0);
        waitNeg(4);
        checkOutput("ch2_cnt_two", dut_a.cnt[2], 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_a", {state_a, down_a, up_a, long_a, any_a}, 0);
        checkOutput("async_reset_b", {state_b, down_b, up_b, long_b, any_b}, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        waitNeg(5);
        checkOutput("post_reset_edge5", {state_a, down_a}, 0);
        waitNeg(1);
        checkOutput("post_reset_edge6", {state_a, down_a, any_a}, {4'b0110, 4'b0110, 1'b1});

        // Random bouncing with occasional mid-cycle resets
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 15) == 0) pb_a[c] = ~pb_a[c];
            end
            hold_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk);
                #3 rst_n = 1'b1;
            end
        end
        waitNeg(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
